// File: rtl/scbd_slot_tracker.sv
// Per-wavefront instruction slot tracker: 40 one-instruction slots filled one or two
// dwords at a time from the instruction buffer, drained by issue and discarded by flush.
module scbd_slot_tracker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        feed_valid,
    input  logic [5:0]  feed_wfid,
    input  logic [31:0] buf_rd_data,
    input  logic        buf_rd_is64,
    input  logic        issue_valid,
    input  logic [5:0]  issue_wfid,
    input  logic        flush_valid,
    input  logic [5:0]  flush_wfid,
    input  logic [5:0]  rd_wfid,
    output logic [63:0] rd_instr,
    output logic [39:0] slot_full,
    output logic [39:0] issue_vacant,
    output logic        ins_half_reqd,
    output logic [5:0]  ins_half_wfid,
    output logic        feed_err
);

    localparam int         NSLOT  = 40;
    localparam logic [5:0] WF_LIM = 6'd40;

    typedef enum logic [2:0] {
        ST_EMPTY   = 3'd0,
        ST_FILL_LO = 3'd1,
        ST_HALF    = 3'd2,
        ST_FILL_HI = 3'd3,
        ST_FULL    = 3'd4
    } slot_state_t;

    slot_state_t r_state [NSLOT];
    logic [31:0] r_lo    [NSLOT];
    logic [31:0] r_hi    [NSLOT];
    logic [39:0] r_full;
    logic [39:0] r_vacant;
    logic        r_half_reqd;
    logic [5:0]  r_half_wfid;
    logic        r_feed_err;
    logic        r_pend_vld;
    logic [5:0]  r_pend_wfid;
    logic        r_pend_hi;

    slot_state_t w_feed_st;
    slot_state_t w_issue_st;
    logic        w_feed_in;
    logic        w_issue_in;
    logic        w_flush_in;
    logic        w_feed_acc;
    logic        w_feed_bad;
    logic        w_issue_acc;
    logic        w_issue_bad;
    logic        w_cap;
    logic        w_cap_half;
    logic [63:0] w_rd_instr;

    function automatic logic can_feed(input slot_state_t st);
        logic ok;
        case (st)
            ST_EMPTY: ok = 1'b1;
            ST_HALF:  ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Decode this cycle's events against pre-edge slot state; flush overrides same-wfid feed/issue.
    always_comb begin
        w_feed_in  = feed_valid  && (feed_wfid  < WF_LIM);
        w_issue_in = issue_valid && (issue_wfid < WF_LIM);
        w_flush_in = flush_valid && (flush_wfid < WF_LIM);
        if (w_feed_in) begin
            w_feed_st = r_state[feed_wfid];
        end else begin
            w_feed_st = ST_EMPTY;
        end
        if (w_issue_in) begin
            w_issue_st = r_state[issue_wfid];
        end else begin
            w_issue_st = ST_EMPTY;
        end
        w_feed_bad  = w_feed_in && !can_feed(w_feed_st);
        w_feed_acc  = w_feed_in && can_feed(w_feed_st)
                      && !(w_flush_in && (flush_wfid == feed_wfid));
        w_issue_bad = w_issue_in && (w_issue_st != ST_FULL);
        w_issue_acc = w_issue_in && (w_issue_st == ST_FULL)
                      && !(w_flush_in && (flush_wfid == issue_wfid));
        w_cap       = r_pend_vld && !(w_flush_in && (flush_wfid == r_pend_wfid));
        w_cap_half  = w_cap && !r_pend_hi && buf_rd_is64;
    end

    // Combinational slot read port; out-of-range selects return zero.
    always_comb begin
        w_rd_instr = 64'd0;
        if (rd_wfid < WF_LIM) begin
            w_rd_instr = {r_hi[rd_wfid], r_lo[rd_wfid]};
        end else begin
            w_rd_instr = 64'd0;
        end
    end

    // Per-slot state and data; at most one of capture/issue/feed can target a slot per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                r_state[i] <= ST_EMPTY;
                r_lo[i]    <= 32'd0;
                r_hi[i]    <= 32'd0;
            end
            r_full <= 40'd0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                if (w_flush_in && (flush_wfid == 6'(i))) begin
                    r_state[i] <= ST_EMPTY;
                    r_lo[i]    <= 32'd0;
                    r_hi[i]    <= 32'd0;
                    r_full[i]  <= 1'b0;
                end else if (w_cap && (r_pend_wfid == 6'(i))) begin
                    if (r_pend_hi) begin
                        r_hi[i]    <= buf_rd_data;
                        r_state[i] <= ST_FULL;
                        r_full[i]  <= 1'b1;
                    end else if (buf_rd_is64) begin
                        r_lo[i]    <= buf_rd_data;
                        r_state[i] <= ST_HALF;
                        r_full[i]  <= 1'b0;
                    end else begin
                        r_lo[i]    <= buf_rd_data;
                        r_hi[i]    <= 32'd0;
                        r_state[i] <= ST_FULL;
                        r_full[i]  <= 1'b1;
                    end
                end else if (w_issue_acc && (issue_wfid == 6'(i))) begin
                    r_state[i] <= ST_EMPTY;
                    r_full[i]  <= 1'b0;
                end else if (w_feed_acc && (feed_wfid == 6'(i))) begin
                    r_state[i] <= (r_state[i] == ST_HALF) ? ST_FILL_HI : ST_FILL_LO;
                    r_full[i]  <= 1'b0;
                end else begin
                    r_state[i] <= r_state[i];
                end
            end
        end
    end

    // Single in-flight fill: data always lands the cycle after acceptance, so one entry suffices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld  <= 1'b0;
            r_pend_wfid <= 6'd0;
            r_pend_hi   <= 1'b0;
        end else if (w_feed_acc) begin
            r_pend_vld  <= 1'b1;
            r_pend_wfid <= feed_wfid;
            r_pend_hi   <= (w_feed_st == ST_HALF);
        end else begin
            r_pend_vld  <= 1'b0;
            r_pend_wfid <= 6'd0;
            r_pend_hi   <= 1'b0;
        end
    end

    // One-cycle pulses and the sticky protocol error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vacant    <= 40'd0;
            r_half_reqd <= 1'b0;
            r_half_wfid <= 6'd0;
            r_feed_err  <= 1'b0;
        end else begin
            r_vacant    <= w_issue_acc ? (40'd1 << issue_wfid) : 40'd0;
            r_half_reqd <= w_cap_half;
            r_half_wfid <= w_cap_half ? r_pend_wfid : 6'd0;
            r_feed_err  <= r_feed_err | w_feed_bad | w_issue_bad;
        end
    end

    assign rd_instr      = w_rd_instr;
    assign slot_full     = r_full;
    assign issue_vacant  = r_vacant;
    assign ins_half_reqd = r_half_reqd;
    assign ins_half_wfid = r_half_wfid;
    assign feed_err      = r_feed_err;

endmodule
